// File: rtl/fp_addsub_pkg.sv
// Shared constants and types for the FP add/sub mantissa datapath.
// Default widths match single precision with three guard/round/sticky bits.
package fp_addsub_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 24;
  localparam int GRS_W_DEF  = 3;

  localparam logic INV_SMALLER = 1'b0;
  localparam logic INV_B       = 1'b1;

  // Stage-1 bundle at the default widths; the pipe re-declares it per parameter set.
  typedef struct packed {
    logic [EXP_W_DEF-1:0]  abs_d;
    logic                  sign_d;
    logic                  zero_d;
    logic [1:0]            cmp;
    logic                  eff_op;
    logic                  inv_mode;
    logic [EXP_W_DEF-1:0]  exp_a;
    logic [EXP_W_DEF-1:0]  exp_b;
    logic [MANT_W_DEF-1:0] mant_a;
    logic [MANT_W_DEF-1:0] mant_b;
  } s1_bundle_t;

endpackage

// File: rtl/fp_align_invert_pipe_if.sv
// Operand-in / aligned-mantissa-out handshake bundle for fp_align_invert_pipe.
// master drives operands and OutReady; slave is the pipe itself.
interface fp_align_invert_pipe_if
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int GRS_W  = GRS_W_DEF
);
  localparam int W = MANT_W + GRS_W;

  logic              InValid;
  logic              InReady;
  logic              EffOp;
  logic              InvMode;
  logic [EXP_W-1:0]  ExpA;
  logic [EXP_W-1:0]  ExpB;
  logic [MANT_W-1:0] MantA;
  logic [MANT_W-1:0] MantB;

  logic              OutValid;
  logic              OutReady;
  logic [W-1:0]      MantL;
  logic [W-1:0]      MantS;
  logic              InvL;
  logic              InvS;
  logic              CarryIn;
  logic [EXP_W-1:0]  ExpOut;
  logic              Swapped;
  logic              ExactZero;

  modport master (
    output InValid, EffOp, InvMode, ExpA, ExpB, MantA, MantB, OutReady,
    input  InReady, OutValid, MantL, MantS, InvL, InvS, CarryIn, ExpOut, Swapped, ExactZero
  );

  modport slave (
    input  InValid, EffOp, InvMode, ExpA, ExpB, MantA, MantB, OutReady,
    output InReady, OutValid, MantL, MantS, InvL, InvS, CarryIn, ExpOut, Swapped, ExactZero
  );

endinterface

// File: rtl/fp_sticky_shifter.sv
// Combinational logical right shift that folds every shifted-out bit into the LSB.
// Shift amounts at or beyond the width collapse the whole word into the sticky bit.
module fp_sticky_shifter #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] shamt,
  output logic [W-1:0]    dout
);

  logic [31:0]  sh;
  logic [W-1:0] lost_mask;

  always_comb begin
    sh        = 32'(shamt);
    lost_mask = '0;
    dout      = '0;
    if (sh >= 32'(W)) begin
      dout = {{(W-1){1'b0}}, |din};
    end else begin
      lost_mask = ~({W{1'b1}} << sh);
      dout      = (din >> sh) | {{(W-1){1'b0}}, |(din & lost_mask)};
    end
  end

endmodule

// File: rtl/fp_align_invert_pipe.sv
// Two-stage swap/align/invert front end of the FP mantissa adder: compares operands,
// routes the larger to the unshifted path, aligns the other with sticky, then inverts.
module fp_align_invert_pipe
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF,
  parameter int GRS_W  = GRS_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_align_invert_pipe_if.slave bus
);

  localparam int W = MANT_W + GRS_W;

  typedef struct packed {
    logic [EXP_W-1:0]  abs_d;
    logic              sign_d;
    logic              zero_d;
    logic [1:0]        cmp;
    logic              eff_op;
    logic              inv_mode;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
  } s1_t;

  function automatic logic [EXP_W:0] exp_diff(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic [EXP_W-1:0] abs_mag(input logic [EXP_W:0] d);
    logic [EXP_W:0] neg;
    neg = -d;
    return d[EXP_W] ? neg[EXP_W-1:0] : d[EXP_W-1:0];
  endfunction

  function automatic logic [W-1:0] cond_invert(input logic [W-1:0] v, input logic inv);
    return v ^ {W{inv}};
  endfunction

  logic             s2_ready;
  logic             vld_p1;
  logic             vld_p2;
  s1_t              s1_next;
  s1_t              s1_p1;
  logic [EXP_W:0]   diff;

  logic             swapped;
  logic [MANT_W-1:0] mant_big;
  logic [MANT_W-1:0] mant_small;
  logic [W-1:0]     aligned;
  logic             inv_l;
  logic             inv_s;
  logic             exact_zero;

  logic [W-1:0]     mant_l_p2;
  logic [W-1:0]     mant_s_p2;
  logic             inv_l_p2;
  logic             inv_s_p2;
  logic [EXP_W-1:0] exp_out_p2;
  logic             swapped_p2;
  logic             exact_zero_p2;

  assign s2_ready    = ~vld_p2 | bus.OutReady;
  assign bus.InReady = ~vld_p1 | s2_ready;

  always_comb begin
    diff             = exp_diff(bus.ExpA, bus.ExpB);
    s1_next          = '0;
    s1_next.sign_d   = diff[EXP_W];
    s1_next.zero_d   = (diff == '0);
    s1_next.abs_d    = abs_mag(diff);
    s1_next.cmp      = {bus.MantA > bus.MantB, bus.MantA < bus.MantB};
    s1_next.eff_op   = bus.EffOp;
    s1_next.inv_mode = bus.InvMode;
    s1_next.exp_a    = bus.ExpA;
    s1_next.exp_b    = bus.ExpB;
    s1_next.mant_a   = bus.MantA;
    s1_next.mant_b   = bus.MantB;
  end

  // Stage 1: exponent difference and mantissa compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      s1_p1  <= '0;
    end else if (bus.InReady) begin
      vld_p1 <= bus.InValid;
      if (bus.InValid) s1_p1 <= s1_next;
    end
  end

  // Equal exponents with equal mantissas keep operand A on the large path.
  assign swapped    = s1_p1.sign_d | (s1_p1.zero_d & s1_p1.cmp[0]);
  assign mant_big   = swapped ? s1_p1.mant_b : s1_p1.mant_a;
  assign mant_small = swapped ? s1_p1.mant_a : s1_p1.mant_b;
  assign exact_zero = s1_p1.eff_op & s1_p1.zero_d & (s1_p1.cmp == 2'b00);

  fp_sticky_shifter #(
    .W    (W),
    .SH_W (EXP_W)
  ) u_shift (
    .din   ({mant_small, {GRS_W{1'b0}}}),
    .shamt (s1_p1.abs_d),
    .dout  (aligned)
  );

  always_comb begin
    if (s1_p1.inv_mode == INV_B) begin
      inv_s = s1_p1.eff_op & ~swapped;
      inv_l = s1_p1.eff_op & swapped;
    end else begin
      inv_s = s1_p1.eff_op;
      inv_l = 1'b0;
    end
  end

  // Stage 2: swap, align, invert
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2        <= 1'b0;
      mant_l_p2     <= '0;
      mant_s_p2     <= '0;
      inv_l_p2      <= 1'b0;
      inv_s_p2      <= 1'b0;
      exp_out_p2    <= '0;
      swapped_p2    <= 1'b0;
      exact_zero_p2 <= 1'b0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mant_l_p2     <= cond_invert({mant_big, {GRS_W{1'b0}}}, inv_l);
        mant_s_p2     <= cond_invert(aligned, inv_s);
        inv_l_p2      <= inv_l;
        inv_s_p2      <= inv_s;
        exp_out_p2    <= swapped ? s1_p1.exp_b : s1_p1.exp_a;
        swapped_p2    <= swapped;
        exact_zero_p2 <= exact_zero;
      end
    end
  end

  assign bus.OutValid  = vld_p2;
  assign bus.MantL     = mant_l_p2;
  assign bus.MantS     = mant_s_p2;
  assign bus.InvL      = inv_l_p2;
  assign bus.InvS      = inv_s_p2;
  assign bus.CarryIn   = inv_l_p2 | inv_s_p2;
  assign bus.ExpOut    = exp_out_p2;
  assign bus.Swapped   = swapped_p2;
  assign bus.ExactZero = exact_zero_p2;

endmodule

// File: tb/tb_fp_align_invert_pipe.sv
// Scoreboard bench for fp_align_invert_pipe: directed vectors with hand-computed results,
// a stalled back-to-back stream, and a reset pulse with work in flight.
module tb_fp_align_invert_pipe;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int GRS_W  = 3;

  typedef struct packed {
    logic [26:0] mant_l;
    logic [26:0] mant_s;
    logic        inv_l;
    logic        inv_s;
    logic        carry_in;
    logic [7:0]  exp_out;
    logic        swapped;
    logic        exact_zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_align_invert_pipe_if #(.EXP_W(EXP_W), .MANT_W(MANT_W), .GRS_W(GRS_W)) bus ();

  fp_align_invert_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W), .GRS_W(GRS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t  sb[$];
  string sb_name[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  res_t  mon_exp;
  string mon_name;

  function automatic res_t actual();
    res_t r;
    r.mant_l     = bus.MantL;
    r.mant_s     = bus.MantS;
    r.inv_l      = bus.InvL;
    r.inv_s      = bus.InvS;
    r.carry_in   = bus.CarryIn;
    r.exp_out    = bus.ExpOut;
    r.swapped    = bus.Swapped;
    r.exact_zero = bus.ExactZero;
    return r;
  endfunction

  function automatic res_t mk(input logic [26:0] l, input logic [26:0] s, input logic il,
                              input logic is, input logic ci, input logic [7:0] e,
                              input logic sw, input logic ez);
    res_t r;
    r.mant_l = l; r.mant_s = s; r.inv_l = il; r.inv_s = is; r.carry_in = ci;
    r.exp_out = e; r.swapped = sw; r.exact_zero = ez;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_res_zero(input string name);
    res_t a;
    a = actual();
    n_tests++;
    if (a !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs %h, expected all zero", name, a);
    end
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (!rst && bus.OutValid && bus.OutReady) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no output", actual());
      end else begin
        mon_exp  = sb.pop_front();
        mon_name = sb_name.pop_front();
        if (actual() !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", mon_name, actual(), mon_exp);
        end
      end
    end
  end

  task automatic send(input string name, input logic eff, input logic mode,
                      input logic [7:0] ea, input logic [7:0] eb,
                      input logic [23:0] ma, input logic [23:0] mb, input res_t exp_r);
    int cnt;
    bus.InValid = 1'b1;
    bus.EffOp   = eff;
    bus.InvMode = mode;
    bus.ExpA    = ea;
    bus.ExpB    = eb;
    bus.MantA   = ma;
    bus.MantB   = mb;
    cnt = 0;
    while (!bus.InReady && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.InReady) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: InReady stuck at 0, expected 1", name);
    end else begin
      sb.push_back(exp_r);
      sb_name.push_back(name);
    end
    @(negedge clk);
    bus.InValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt = 0;
    while (sb.size() != 0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst          = 1'b1;
    bus.InValid  = 1'b0;
    bus.EffOp    = 1'b0;
    bus.InvMode  = 1'b0;
    bus.ExpA     = '0;
    bus.ExpB     = '0;
    bus.MantA    = '0;
    bus.MantB    = '0;
    bus.OutReady = 1'b1;
    repeat (2) @(negedge clk);
    check_res_zero("reset_outputs");
    check("reset_outvalid", 32'(bus.OutValid), 32'd0);
    check("reset_inready", 32'(bus.InReady), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single transaction: one edge into stage 1, the next makes it visible.
    send("sub_shift2", 1, 0, 8'h85, 8'h83, 24'hC00000, 24'h800000,
         mk(27'h6000000, 27'h6FFFFFF, 0, 1, 1, 8'h85, 0, 0));
    check("latency_early", 32'(bus.OutValid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(bus.OutValid), 32'd1);
    drain("drain_first");

    send("sub_eq_exp_swap", 1, 0, 8'h80, 8'h80, 24'h900000, 24'hA00000,
         mk(27'h5000000, 27'h37FFFFF, 0, 1, 1, 8'h80, 1, 0));
    send("exact_zero_sub", 1, 0, 8'h90, 8'h90, 24'hABCDEF, 24'hABCDEF,
         mk(27'h55E6F78, 27'h2A19087, 0, 1, 1, 8'h90, 0, 1));
    send("equal_add", 0, 0, 8'h90, 8'h90, 24'hABCDEF, 24'hABCDEF,
         mk(27'h55E6F78, 27'h55E6F78, 0, 0, 0, 8'h90, 0, 0));
    send("align_sat", 0, 0, 8'hFE, 8'h01, 24'h800000, 24'h800001,
         mk(27'h4000000, 27'h0000001, 0, 0, 0, 8'hFE, 0, 0));
    send("sticky_shift5", 0, 0, 8'h85, 8'h80, 24'h800000, 24'h800001,
         mk(27'h4000000, 27'h0200001, 0, 0, 0, 8'h85, 0, 0));
    send("invb_swapped", 1, 1, 8'h80, 8'h82, 24'h800000, 24'hC00000,
         mk(27'h1FFFFFF, 27'h1000000, 1, 0, 1, 8'h82, 1, 0));
    send("invb_not_swapped", 1, 1, 8'h82, 8'h80, 24'hC00000, 24'h800000,
         mk(27'h6000000, 27'h6FFFFFF, 0, 1, 1, 8'h82, 0, 0));
    send("sat_sub_swapped", 1, 0, 8'h01, 8'h40, 24'h800000, 24'hFFFFFF,
         mk(27'h7FFFFF8, 27'h7FFFFFE, 0, 1, 1, 8'h40, 1, 0));
    drain("drain_directed");

    // Stream of 8 with a 3-edge output stall once the pipe is flowing.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send($sformatf("stream%0d", i), 0, 0, 8'(8'h80 + i), 8'h80, 24'h800000, 24'h800000,
               mk(27'h4000000, 27'(27'h4000000 >> i), 0, 0, 0, 8'(8'h80 + i), 0, 0));
        end
      end
      begin
        cnt = 0;
        while (!bus.OutValid && cnt < 50) begin
          @(negedge clk);
          cnt++;
        end
        check("stream_started", 32'(bus.OutValid), 32'd1);
        @(posedge clk);
        #1 bus.OutReady = 1'b0;
        repeat (2) @(negedge clk);
        check("full_inready", 32'(bus.InReady), 32'd0);
        check("full_outvalid", 32'(bus.OutValid), 32'd1);
        repeat (2) @(posedge clk);
        #1 bus.OutReady = 1'b1;
      end
    join
    drain("drain_stream");

    // Reset with both stages occupied: everything in flight is discarded.
    @(posedge clk);
    #1 bus.OutReady = 1'b0;
    @(negedge clk);
    send("discard_a", 1, 0, 8'h85, 8'h83, 24'hC00000, 24'h800000,
         mk(27'h6000000, 27'h6FFFFFF, 0, 1, 1, 8'h85, 0, 0));
    send("discard_b", 0, 0, 8'h85, 8'h80, 24'h800000, 24'h800001,
         mk(27'h4000000, 27'h0200001, 0, 0, 0, 8'h85, 0, 0));
    check("pre_rst_outvalid", 32'(bus.OutValid), 32'd1);
    check("pre_rst_inready", 32'(bus.InReady), 32'd0);
    #2 rst = 1'b1;
    sb.delete();
    sb_name.delete();
    #1;
    check("rst_async_outvalid", 32'(bus.OutValid), 32'd0);
    check_res_zero("rst_async_outputs");
    check("rst_inready", 32'(bus.InReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 bus.OutReady = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_quiet", 32'(bus.OutValid), 32'd0);

    send("post_rst_sub", 1, 0, 8'h80, 8'h80, 24'h900000, 24'hA00000,
         mk(27'h5000000, 27'h37FFFFF, 0, 1, 1, 8'h80, 1, 0));
    drain("drain_post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
